// File: rtl/branch_pred.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry 2-bit saturating counters.
//
// Ports:
//   clk, nreset          clock and asynchronous active-low reset
//   ena                  global enable; low freezes all state and forces pred_taken to 0
//   f_pc                 fetch PC looked up combinationally
//   pred_taken           predict taken (hit with counter in a taken state)
//   pred_target          stored target on a hit, else 0
//   u_valid, u_pc,       resolution-stage update: PC, actual target, actual outcome
//   u_target, u_taken,   and the prediction made at fetch
//   u_pred
//   mispredict           registered pulse one cycle after an update with u_taken != u_pred
//   br_count, mp_count   saturating counts of accepted updates and of mispredicts

module branch_pred #(
    parameter int unsigned IDX_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             ena,
    input  logic [31:0]      f_pc,
    output logic             pred_taken,
    output logic [31:0]      pred_target,
    input  logic             u_valid,
    input  logic [31:0]      u_pc,
    input  logic [31:0]      u_target,
    input  logic             u_taken,
    input  logic             u_pred,
    output logic             mispredict,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mp_count
);

    localparam int unsigned Entries = 1 << IDX_W;
    localparam int unsigned TagW    = 30 - IDX_W;

    logic [Entries-1:0] valid_q;
    logic [1:0]         ctr_q    [Entries];
    logic [TagW-1:0]    tag_q    [Entries];
    logic [31:0]        target_q [Entries];

    logic [CNT_W-1:0]   br_count_q, mp_count_q;
    logic               mispredict_q;

    logic [IDX_W-1:0]   f_idx, u_idx;
    logic [TagW-1:0]    f_tag, u_tag;
    logic               f_hit, u_hit, upd, upd_mp;

    // pc[1:0] and the target LSB never reach the table
    logic unused_bits;
    assign unused_bits = ^{f_pc[1:0], u_pc[1:0], u_target[0]};

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[31:IDX_W+2];
    assign u_idx = u_pc[IDX_W+1:2];
    assign u_tag = u_pc[31:IDX_W+2];

    assign upd    = ena && u_valid;
    assign upd_mp = upd && (u_taken != u_pred);

    // Lookup reads current state only, so a same-cycle update is not visible until next cycle
    always_comb begin
        f_hit       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
        pred_taken  = ena && f_hit && ctr_q[f_idx][1];
        pred_target = f_hit ? target_q[f_idx] : 32'h0;
        u_hit       = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    end

    // Tags and targets carry no reset; valid gates their use
    always_ff @(posedge clk) begin
        if (upd && u_taken) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= {u_target[31:1], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            valid_q      <= '0;
            for (int i = 0; i < Entries; i++) begin
                ctr_q[i] <= 2'b01;
            end
            br_count_q   <= '0;
            mp_count_q   <= '0;
            mispredict_q <= 1'b0;
        end else begin
            mispredict_q <= upd_mp;
            if (upd) begin
                if (u_hit) begin
                    if (u_taken && (ctr_q[u_idx] != 2'b11)) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
                    end else if (!u_taken && (ctr_q[u_idx] != 2'b00)) begin
                        ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
                    end
                end else if (u_taken) begin
                    // Allocate weakly taken, evicting any aliasing occupant
                    valid_q[u_idx] <= 1'b1;
                    ctr_q[u_idx]   <= 2'b10;
                end
                if (br_count_q != {CNT_W{1'b1}}) begin
                    br_count_q <= br_count_q + 1'b1;
                end
                if (upd_mp && (mp_count_q != {CNT_W{1'b1}})) begin
                    mp_count_q <= mp_count_q + 1'b1;
                end
            end
        end
    end

    assign mispredict = mispredict_q;
    assign br_count   = br_count_q;
    assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_pred.sv
// Self-checking bench for branch_pred: directed scenarios followed by random traffic, all
// compared against a behavioural model of the predictor table and counters.

module tb_branch_pred;

    localparam int unsigned IDX_W = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned ENT   = 1 << IDX_W;
    localparam int unsigned CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             nreset = 1'b0;
    logic             ena = 1'b0;
    logic [31:0]      f_pc = '0;
    logic             pred_taken;
    logic [31:0]      pred_target;
    logic             u_valid = 1'b0;
    logic [31:0]      u_pc = '0;
    logic [31:0]      u_target = '0;
    logic             u_taken = 1'b0;
    logic             u_pred = 1'b0;
    logic             mispredict;
    logic [CNT_W-1:0] br_count;
    logic [CNT_W-1:0] mp_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-slot valid, owning address (pc/4), target, counter 0..3
    bit          m_valid  [ENT];
    int unsigned m_owner  [ENT];
    int unsigned m_target [ENT];
    int          m_ctr    [ENT];
    int unsigned m_br, m_mp;
    bit          m_misp;

    branch_pred #(
        .IDX_W(IDX_W),
        .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .ena        (ena),
        .f_pc       (f_pc),
        .pred_taken (pred_taken),
        .pred_target(pred_target),
        .u_valid    (u_valid),
        .u_pc       (u_pc),
        .u_target   (u_target),
        .u_taken    (u_taken),
        .u_pred     (u_pred),
        .mispredict (mispredict),
        .br_count   (br_count),
        .mp_count   (mp_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
        end
        m_br   = 0;
        m_mp   = 0;
        m_misp = 1'b0;
    endfunction

    function automatic int unsigned slot_of(input logic [31:0] pc);
        return (pc / 4) % ENT;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot_of(pc)] && (m_owner[slot_of(pc)] == pc / 4);
    endfunction

    function automatic void m_update(input bit e, input bit uv, input logic [31:0] pc,
                                     input logic [31:0] tgt, input bit tk, input bit pr);
        int unsigned s;
        m_misp = e && uv && (tk != pr);
        if (!(e && uv)) return;
        s = slot_of(pc);
        if (m_hit(pc)) begin
            m_ctr[s] = tk ? ((m_ctr[s] + 1 > 3) ? 3 : m_ctr[s] + 1)
                          : ((m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1);
            if (tk) m_target[s] = tgt & 32'hFFFF_FFFE;
        end else if (tk) begin
            m_valid[s]  = 1'b1;
            m_owner[s]  = pc / 4;
            m_target[s] = tgt & 32'hFFFF_FFFE;
            m_ctr[s]    = 2;
        end
        if (m_br < CMAX) m_br++;
        if (tk != pr && m_mp < CMAX) m_mp++;
    endfunction

    task automatic check_lookup();
        bit h;
        h = m_hit(f_pc);
        check("pred_taken", {31'b0, pred_taken}, {31'b0, ena && h && m_ctr[slot_of(f_pc)] >= 2});
        check("pred_target", pred_target, h ? m_target[slot_of(f_pc)] : 32'h0);
    endtask

    task automatic check_regs();
        check("mispredict", {31'b0, mispredict}, {31'b0, m_misp});
        check("br_count", 32'(br_count), m_br);
        check("mp_count", 32'(mp_count), m_mp);
    endtask

    // One clock: drive at negedge, check lookup before the edge, check registers after it
    task automatic cycle(input bit e, input logic [31:0] fp, input bit uv,
                         input logic [31:0] up, input logic [31:0] ut, input bit tk, input bit pr);
        @(negedge clk);
        ena = e; f_pc = fp; u_valid = uv; u_pc = up; u_target = ut; u_taken = tk; u_pred = pr;
        #1;
        check_lookup();
        @(posedge clk);
        #1;
        m_update(e, uv, up, ut, tk, pr);
        check_regs();
    endtask

    task automatic look(input logic [31:0] fp);
        cycle(1'b1, fp, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges with an update pending; the update is lost
    task automatic do_reset(input logic [31:0] fp);
        @(negedge clk);
        ena = 1'b1; f_pc = fp; u_valid = 1'b1; u_pc = fp; u_target = 32'h44;
        u_taken = 1'b1; u_pred = 1'b0;
        #2;
        nreset = 1'b0;
        m_reset();
        #1;
        check_lookup();
        check_regs();
        @(posedge clk);
        #1;
        check_lookup();
        check_regs();
        @(negedge clk);
        nreset = 1'b1;
        u_valid = 1'b0;
    endtask

    initial begin
        m_reset();
        f_pc = 32'h100;
        #12;
        check("reset pred_taken", {31'b0, pred_taken}, 32'h0);
        check("reset pred_target", pred_target, 32'h0);
        check_regs();
        @(negedge clk);
        nreset = 1'b1;

        // Allocate, then hysteresis on the same entry
        cycle(1, 32'h100, 1, 32'h100, 32'h80, 1, 0);
        look(32'h100);
        check("alloc taken", {31'b0, pred_taken}, 32'h1);
        check("alloc target", pred_target, 32'h80);
        cycle(1, 32'h100, 1, 32'h100, 32'h80, 0, 1);
        look(32'h100);
        cycle(1, 32'h100, 1, 32'h100, 32'h81, 1, 0);
        cycle(1, 32'h100, 1, 32'h100, 32'h81, 1, 1);
        cycle(1, 32'h100, 1, 32'h100, 32'h80, 1, 1);
        cycle(1, 32'h100, 1, 32'h100, 32'h80, 0, 1);
        look(32'h100);
        check("hysteresis taken", {31'b0, pred_taken}, 32'h1);

        // Aliasing at the same index
        cycle(1, 32'h100, 1, 32'h140, 32'h300, 1, 0);
        look(32'h100);
        look(32'h140);

        // Read-before-write, then a not-taken miss that must not allocate
        cycle(1, 32'h200, 1, 32'h200, 32'h40, 1, 1);
        look(32'h200);
        cycle(1, 32'h300, 1, 32'h304, 32'h10, 0, 0);
        look(32'h304);

        // Disabled: nothing changes, prediction suppressed
        cycle(0, 32'h200, 1, 32'h200, 32'h0, 0, 1);
        cycle(0, 32'h208, 1, 32'h208, 32'h20, 1, 0);
        look(32'h200);
        look(32'h208);

        // Counter saturation from a clean start
        do_reset(32'h100);
        for (int i = 0; i < 10; i++) begin
            cycle(1, 32'h100, 1, 32'h100 + 32'(i * 4), 32'h500, 1, 0);
        end
        check("mp saturated", 32'(mp_count), CMAX);

        // Random traffic over a small aliasing address space
        do_reset(32'h40);
        for (int i = 0; i < 600; i++) begin
            logic [31:0] fp, up;
            fp = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, 3) << 2)
                 | $urandom_range(0, 3);
            up = ($urandom_range(0, 3) << (IDX_W + 2)) | ($urandom_range(0, 3) << 2)
                 | $urandom_range(0, 3);
            if (i == 300) do_reset(fp);
            cycle($urandom_range(0, 9) != 0, fp, $urandom_range(0, 3) != 0, up, $urandom,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
